// File: rtl/fetch_pkg.sv
// Shared types for the byte-serial instruction fetch unit and its prefetch buffer.
package fetch_pkg;

  localparam int INSTR_BYTES = 4;
  // Widest word address the prefetch entry can carry; instr_fetch uses the low addr_size bits.
  localparam int ADDR_MAX_W  = 32;

  typedef logic [31:0] instr_t;

  typedef struct packed {
    instr_t                  word;
    logic [ADDR_MAX_W-1:0]   addr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: power-of-two FIFO, head visible the cycle after push, flush beats push/pop.
// Push while full and pop while empty are ignored, so the caller never has to guard them.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  depth   = 2,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         push,
  input  entry_t                       push_dat,
  input  logic                         pop,
  input  logic                         flush,
  output logic [$clog2(depth+1)-1:0]   count,
  output entry_t                       head,
  output logic                         empty,
  output logic                         full
);

  localparam int PTR_W = $clog2(depth);
  localparam int CNT_W = $clog2(depth + 1);

  entry_t             r_mem [depth];
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CNT_W'(depth));
  assign count     = r_count;
  assign head      = r_mem[r_rptr];
  assign w_do_push = push & ~flush & ~full;
  assign w_do_pop  = pop  & ~flush & ~empty;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= push_dat;
    end
  end

  // Pointers wrap naturally because depth is a power of two.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Byte-serial instruction fetch: assembles 4 ROM bytes (MSB first) into a word, 4 cycles per word at full ack.
// ROM requests stop while the prefetch buffer is full; a jump flushes buffer and partial word.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int addr_size = 16,
  parameter int depth     = 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   jmp,
  input  logic [addr_size-1:0]   jaddr,
  output logic                   mem_req,
  output logic [addr_size+1:0]   mem_addr,
  input  logic                   mem_ack,
  input  logic [7:0]             mem_data,
  output logic                   instr_valid,
  output logic [31:0]            instr,
  output logic [addr_size-1:0]   instr_addr,
  input  logic                   instr_ready
);

  localparam int CNT_W = $clog2(depth + 1);

  logic [addr_size-1:0] r_pc;
  logic [1:0]           r_byte_idx;
  instr_t               r_asm;

  logic                 w_accept;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_empty;
  logic                 w_full;
  logic [CNT_W-1:0]     w_count;
  fetch_entry_t         w_push_dat;
  fetch_entry_t         w_head;

  assign mem_req  = ~w_full;
  assign mem_addr = {r_pc, r_byte_idx};
  assign w_accept = mem_req & mem_ack;
  assign w_push   = w_accept & (r_byte_idx == 2'd3);
  assign w_pop    = instr_valid & instr_ready;

  // The last byte goes straight into the pushed word so the entry is ready on the same edge.
  always_comb begin
    w_push_dat                     = '0;
    w_push_dat.word                = {r_asm[31:8], mem_data};
    w_push_dat.addr[addr_size-1:0] = r_pc;
  end

  fetch_fifo #(
    .depth   (depth),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .push     (w_push),
    .push_dat (w_push_dat),
    .pop      (w_pop),
    .flush    (jmp),
    .count    (w_count),
    .head     (w_head),
    .empty    (w_empty),
    .full     (w_full)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pc       <= '0;
      r_byte_idx <= '0;
      r_asm      <= '0;
    end else if (jmp) begin
      r_pc       <= jaddr;
      r_byte_idx <= '0;
      r_asm      <= '0;
    end else if (w_accept) begin
      case (r_byte_idx)
        2'd0:    r_asm[31:24] <= mem_data;
        2'd1:    r_asm[23:16] <= mem_data;
        2'd2:    r_asm[15:8]  <= mem_data;
        default: r_asm[7:0]   <= mem_data;
      endcase
      r_byte_idx <= r_byte_idx + 2'd1;
      if (r_byte_idx == 2'd3) begin
        r_pc <= r_pc + addr_size'(1);
      end
    end
  end

  assign instr_valid = ~w_empty;
  assign instr       = instr_valid ? w_head.word : '0;
  assign instr_addr  = instr_valid ? w_head.addr[addr_size-1:0] : '0;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter addr_size, default 16: instruction word-address width.
REQ-002 Parameter depth, default 2: prefetch buffer entries, power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 jmp  input  1  redirect request, sampled on the clk edge.
REQ-006 jaddr  input  addr_size  redirect target word address.
REQ-007 mem_req  output  1  byte read request to ROM.
REQ-008 mem_addr  output  addr_size+2  byte address = {pc, byte_idx}.
REQ-009 mem_ack  input  1  mem_data valid this cycle; counts only while mem_req=1.
REQ-010 mem_data  input  8  ROM byte.
REQ-011 instr_valid  output  1  buffer head holds a complete instruction.
REQ-012 instr  output  32  head instruction word.
REQ-013 instr_addr  output  addr_size  word address of head instruction.
REQ-014 instr_ready  input  1  consumer (Decoder side) accepts head this cycle.

Function
REQ-015 mem_req is combinational, =1 iff buffer count < depth; mem_addr is combinational from pc and byte_idx.
REQ-016 byte_idx is a 2-bit counter; each accepted byte (mem_req & mem_ack) is written into the assembly register, then byte_idx increments.
REQ-017 Byte order: byte_idx 0 -> instr[31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0].
REQ-018 On the byte_idx=3 accepted byte: the complete word and pc are pushed into the buffer, byte_idx wraps to 0, and pc increments modulo 2^addr_size (0xFFFF -> 0x0000).
REQ-019 Latency: with mem_ack held at 1, a word takes 4 cycles; instr_valid rises on the edge that accepts byte 3.
REQ-020 Pop occurs when instr_valid & instr_ready; the next entry, if any, is presented in the following cycle.
REQ-021 A push and a pop in the same cycle leave count unchanged; overflow is impossible because of REQ-015.
REQ-022 instr and instr_addr are 0 whenever instr_valid=0.
REQ-023 When the buffer is full, mem_req=0, the assembly register holds, and mem_ack is ignored.
REQ-024 jmp=1 at an edge: the buffer is emptied, the partial word is discarded, byte_idx becomes 0, pc becomes jaddr, and any pop, push or byte accepted in that cycle is dropped.
REQ-025 jmp has priority over every other event in the same cycle.
REQ-026 Any bytes already accepted for a word are kept across stall cycles (mem_ack=0); only jmp or reset discards them.

Reset
REQ-027 While rstn=0: pc=0, byte_idx=0, buffer count=0, assembly register=0, instr_valid=0, instr=0, instr_addr=0, mem_req=1, mem_addr=0.
REQ-028 mem_ack is ignored while rstn=0.
REQ-029 An asserted rstn aborts any in-progress word; the first fetch after release is at byte address 0.

Structure
REQ-030 Shared package fetch_pkg holds: INSTR_BYTES=4; typedef instr_t (logic [31:0]); struct fetch_entry_t {instr_t word; addr field}.
REQ-031 Sub-module fetch_fifo (parameters depth and entry type) holds the buffer, with push, pop, flush, count, head, empty and full.
REQ-032 The control logic is not a separate state machine; state = byte_idx plus FIFO count.

Verification
REQ-033 Reset release, ROM bytes 0x11 0x22 0x33 0x44 with ack every cycle, instr_ready=0 -> instr_valid after 4th ack, instr=0x11223344, instr_addr=0.
REQ-034 Continuous ack with instr_ready=0 -> after 8 bytes count=2, mem_req=0, mem_addr=0x0008, further acks ignored; one pop -> mem_req=1 next cycle.
REQ-035 jmp=1 with jaddr=0x0040 while byte_idx=2 and 1 entry buffered -> next cycle instr_valid=0, mem_addr=0x0100, the fresh word reports instr_addr=0x0040.
REQ-036 pc=0xFFFF, fetch one word -> instr_addr=0xFFFF, next mem_addr=0x00000.
REQ-037 Buffer full, push-completing byte not possible, simultaneous pop + accepted byte 3 at count=1 -> count stays 1, order preserved (FIFO ordering checked over 16 words against a scoreboard).
REQ-038 rstn pulled low mid-word (byte_idx=2) -> outputs immediately at reset values; after release the first instruction comes from address 0.
